// File: rtl/dual_issue_scheduler_if.sv
// dual_issue_scheduler_if: fetch, writeback and issue signals of the dual-issue scheduler.
interface dual_issue_scheduler_if;
  logic [31:0] instruction0;
  logic [31:0] instruction1;
  logic        nothing_filled;
  logic        mem_busy;
  logic        wb0_valid;
  logic [4:0]  wb0_rd;
  logic        wb1_valid;
  logic [4:0]  wb1_rd;
  logic        freeze1;
  logic        freeze2;
  logic        dependency_on_ins2;
  logic        issue0_valid;
  logic [31:0] issue0_instr;
  logic        issue1_valid;
  logic [31:0] issue1_instr;
  logic [1:0]  sched_state;
  logic [7:0]  stall_cycles;
  modport master (
    output instruction0, instruction1, nothing_filled, mem_busy,
           wb0_valid, wb0_rd, wb1_valid, wb1_rd,
    input  freeze1, freeze2, dependency_on_ins2, issue0_valid, issue0_instr,
           issue1_valid, issue1_instr, sched_state, stall_cycles
  );
  modport slave (
    input  instruction0, instruction1, nothing_filled, mem_busy,
           wb0_valid, wb0_rd, wb1_valid, wb1_rd,
    output freeze1, freeze2, dependency_on_ins2, issue0_valid, issue0_instr,
           issue1_valid, issue1_instr, sched_state, stall_cycles
  );
endinterface

// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: scoreboarded RV32I issue of up to two instructions per cycle.
// Define SCHED_DUAL_ISSUE_EN to allow pipe-1 issue; otherwise only instruction0 issues.
module dual_issue_scheduler (
  input logic                   clk,
  input logic                   n_rst,
  dual_issue_scheduler_if.slave bus
);
  localparam logic [1:0] EMPTY = 2'd0, RUN = 2'd1, STALL = 2'd2;
  localparam logic [6:0] OP_R = 7'b0110011, LOAD = 7'b0000011, STORE = 7'b0100011,
                         BRANCH = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
                         LUI = 7'b0110111, AUIPC = 7'b0010111;
  function automatic logic [31:0] read_mask(input logic [31:0] i);
    logic use1, use2;
    use1 = !(i[6:0] == LUI || i[6:0] == AUIPC || i[6:0] == JAL);
    use2 = i[6:0] == OP_R || i[6:0] == STORE || i[6:0] == BRANCH;
    read_mask = ((use1 ? 32'd1 << i[19:15] : 32'd0) | (use2 ? 32'd1 << i[24:20] : 32'd0)) & ~32'd1;
  endfunction
  function automatic logic [31:0] write_mask(input logic [31:0] i);
    write_mask = (i[6:0] == STORE || i[6:0] == BRANCH) ? 32'd0 : (32'd1 << i[11:7]) & ~32'd1;
  endfunction
  function automatic logic redirects(input logic [6:0] op);
    redirects = op == BRANCH || op == JAL || op == JALR;
  endfunction
  logic [31:0] pending, rm0, rm1, wm0, wm1, set_mask, clr_mask;
  logic [1:0]  state, next_state;
  logic        issue, dep, hazard1;
  assign rm0 = read_mask(bus.instruction0);
  assign rm1 = read_mask(bus.instruction1);
  assign wm0 = write_mask(bus.instruction0);
  assign wm1 = write_mask(bus.instruction1);
  assign hazard1 = !bus.nothing_filled && |(rm0 & pending);
  assign issue = !bus.nothing_filled && !hazard1 && !bus.mem_busy;
`ifdef SCHED_DUAL_ISSUE_EN
  assign dep = issue && (|(rm1 & wm0) || |(wm1 & wm0) || |(rm1 & pending) ||
                         redirects(bus.instruction1[6:0]) || bus.instruction1[6:0] == LOAD ||
                         bus.instruction1[6:0] == STORE || redirects(bus.instruction0[6:0]) ||
                         bus.instruction1 == 32'd0);
`else
  assign dep = issue;
`endif
  assign clr_mask = (bus.wb0_valid ? 32'd1 << bus.wb0_rd : 32'd0) | (bus.wb1_valid ? 32'd1 << bus.wb1_rd : 32'd0);
  assign set_mask = issue ? (wm0 | (dep ? 32'd0 : wm1)) : 32'd0;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= EMPTY;
    else state <= next_state;
  always_comb next_state = bus.nothing_filled ? EMPTY : (hazard1 || bus.mem_busy) ? STALL : RUN;
  always_comb begin
    bus.freeze1 = hazard1;
    bus.freeze2 = bus.mem_busy;
    bus.dependency_on_ins2 = dep;
    bus.sched_state = state;
  end
  // Set wins over a same-cycle writeback clear of the same register.
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      pending <= '0;
      bus.issue0_valid <= 1'b0;
      bus.issue0_instr <= '0;
      bus.issue1_valid <= 1'b0;
      bus.issue1_instr <= '0;
      bus.stall_cycles <= '0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
      bus.issue0_valid <= issue;
      bus.issue0_instr <= issue ? bus.instruction0 : '0;
      bus.issue1_valid <= issue && !dep;
      bus.issue1_instr <= (issue && !dep) ? bus.instruction1 : '0;
      bus.stall_cycles <= next_state == STALL ? (bus.stall_cycles == 8'hff ? bus.stall_cycles : bus.stall_cycles + 8'd1)
                        : (state == STALL && next_state == RUN) ? 8'd0 : bus.stall_cycles;
    end
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb_dual_issue_scheduler: directed and random stimulus against a per-register reference model.
module tb_dual_issue_scheduler;
  logic clk = 0, n_rst = 0;
  dual_issue_scheduler_if bus();
  dual_issue_scheduler dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;
  int passed = 0, total = 0;
  bit [31:0] m_pend;
  bit m_i0v, m_i1v;
  logic [31:0] m_i0, m_i1;
  int m_state, m_stall;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask
  function automatic bit reads(input logic [31:0] ins, input int r);
    logic [6:0] op;
    bit u1, u2;
    op = ins[6:0];
    u1 = op != 7'b0110111 && op != 7'b0010111 && op != 7'b1101111;
    u2 = op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
    return r != 0 && ((u1 && int'(ins[19:15]) == r) || (u2 && int'(ins[24:20]) == r));
  endfunction
  function automatic bit writes(input logic [31:0] ins, input int r);
    return r != 0 && ins[6:0] != 7'b0100011 && ins[6:0] != 7'b1100011 && int'(ins[11:7]) == r;
  endfunction
  function automatic bit is_jump(input logic [31:0] ins);
    return ins[6:0] == 7'b1100011 || ins[6:0] == 7'b1101111 || ins[6:0] == 7'b1100111;
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1);
    logic [31:0] v;
    v = {12'd1, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    return v;
  endfunction
  function automatic logic [31:0] rand_ins();
    logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [31:0] v;
    if ($urandom_range(0, 9) == 0) return 32'd0;
    v = $urandom;
    v[6:0] = ops[$urandom_range(0, 8)];
    v[11:7] = 5'($urandom_range(0, 7));
    v[19:15] = 5'($urandom_range(0, 7));
    v[24:20] = 5'($urandom_range(0, 7));
    return v;
  endfunction
  task automatic check_regs(input string tag);
    chk({tag, ".issue0_valid"}, bus.issue0_valid, m_i0v);
    chk({tag, ".issue0_instr"}, bus.issue0_instr, m_i0);
    chk({tag, ".issue1_valid"}, bus.issue1_valid, m_i1v);
    chk({tag, ".issue1_instr"}, bus.issue1_instr, m_i1);
    chk({tag, ".sched_state"}, bus.sched_state, m_state);
    chk({tag, ".stall_cycles"}, bus.stall_cycles, m_stall);
    chk({tag, ".pending"}, dut.pending, m_pend);
  endtask
  task automatic step(input string tag, input logic [31:0] i0, input logic [31:0] i1, input bit nf,
                      input bit mb, input bit w0v, input int w0r, input bit w1v, input int w1r);
    bit f1, go, dep;
    int nxt;
    bus.instruction0 = i0; bus.instruction1 = i1; bus.nothing_filled = nf; bus.mem_busy = mb;
    bus.wb0_valid = w0v; bus.wb0_rd = 5'(w0r); bus.wb1_valid = w1v; bus.wb1_rd = 5'(w1r);
    #1;
    f1 = 0;
    for (int r = 1; r < 32; r++) if (!nf && m_pend[r] && reads(i0, r)) f1 = 1;
    go = !nf && !f1 && !mb;
    dep = go;
`ifdef SCHED_DUAL_ISSUE_EN
    if (go) begin
      dep = i1 == 0 || is_jump(i1) || i1[6:0] == 7'b0000011 || i1[6:0] == 7'b0100011 || is_jump(i0);
      for (int r = 1; r < 32; r++)
        if ((reads(i1, r) && writes(i0, r)) || (writes(i1, r) && writes(i0, r)) || (reads(i1, r) && m_pend[r])) dep = 1;
    end
`endif
    chk({tag, ".freeze1"}, bus.freeze1, f1);
    chk({tag, ".freeze2"}, bus.freeze2, mb);
    chk({tag, ".dependency_on_ins2"}, bus.dependency_on_ins2, dep);
    nxt = nf ? 0 : (f1 || mb) ? 2 : 1;
    @(posedge clk);
    for (int r = 1; r < 32; r++) begin
      if ((w0v && w0r == r) || (w1v && w1r == r)) m_pend[r] = 0;
      if ((go && writes(i0, r)) || (go && !dep && writes(i1, r))) m_pend[r] = 1;
    end
    m_i0v = go; m_i0 = go ? i0 : 0;
    m_i1v = go && !dep; m_i1 = (go && !dep) ? i1 : 0;
    if (nxt == 2) m_stall = m_stall < 255 ? m_stall + 1 : 255;
    else if (m_state == 2 && nxt == 1) m_stall = 0;
    m_state = nxt;
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask
  task automatic pulse_reset();
    #2 n_rst = 0;
    #1;
    m_pend = 0; m_i0v = 0; m_i1v = 0; m_i0 = 0; m_i1 = 0; m_state = 0; m_stall = 0;
    check_regs("reset_pulse");
    @(negedge clk);
    n_rst = 1;
  endtask
  initial begin
    bus.instruction0 = 0; bus.instruction1 = 0; bus.nothing_filled = 1; bus.mem_busy = 0;
    bus.wb0_valid = 0; bus.wb0_rd = 0; bus.wb1_valid = 0; bus.wb1_rd = 0;
    m_pend = 0; m_i0v = 0; m_i1v = 0; m_i0 = 0; m_i1 = 0; m_state = 0; m_stall = 0;
    #1 check_regs("reset");
    @(negedge clk);
    n_rst = 1;
    step("empty", 0, 0, 1, 0, 0, 0, 0, 0);
    step("raw_pair", addi(1, 0), addi(2, 1), 0, 0, 0, 0, 0, 0);
    step("fill_x5", addi(5, 0), 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step("stall_x5", addi(6, 5), addi(9, 0), 0, 0, 0, 0, 0, 0);
    step("wb_x5", addi(6, 5), addi(9, 0), 0, 0, 1, 5, 0, 0);
    step("resume", addi(6, 5), addi(9, 0), 0, 0, 0, 0, 0, 0);
    step("indep_pair", addi(3, 0), addi(4, 0), 0, 0, 1, 1, 1, 6);
    step("set_wins", addi(7, 0), 0, 0, 0, 0, 0, 1, 7);
    step("wb_in_empty", 0, 0, 1, 0, 1, 3, 1, 4);
    for (int k = 0; k < 300; k++) step("mem_busy", addi(8, 0), addi(10, 0), 0, 1, 0, 0, 0, 0);
    chk("stall_sat", bus.stall_cycles, 255);
    pulse_reset();
    step("after_reset", addi(11, 0), addi(12, 0), 0, 1, 0, 0, 0, 0);
    step("release", addi(11, 0), addi(12, 0), 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      step("rand", rand_ins(), rand_ins(), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 7));
      if (k == 300) pulse_reset();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
